// File: rtl/loop_nco_if.sv
// Bundle of loop_nco control inputs and oscillator/lock outputs.
// The master modport drives the loop-side inputs; the slave modport is the NCO.
interface loop_nco_if;
    logic        clkEn;
    logic [31:0] freqIn;
    logic [31:0] centerFreq;
    logic [11:0] error;
    logic [15:0] lockCount;
    logic [11:0] syncThreshold;
    logic [31:0] phase;
    logic        ncoEn;
    logic        ncoHalfEn;
    logic        lock;
    logic [1:0]  lockState;

    modport master (
        output clkEn, freqIn, centerFreq, error, lockCount, syncThreshold,
        input  phase, ncoEn, ncoHalfEn, lock, lockState
    );

    modport slave (
        input  clkEn, freqIn, centerFreq, error, lockCount, syncThreshold,
        output phase, ncoEn, ncoHalfEn, lock, lockState
    );
endinterface

// File: rtl/loop_nco.sv
// Loop NCO: phase accumulator with wrap/half-cycle enables and a lock tracker.
// Define LOOP_NCO_FLYWHEEL_EN to coast on a frozen frequency after lock loss.
module loop_nco (
    input logic     clk,
    input logic     reset,
    loop_nco_if.slave bus
);
    typedef enum logic [1:0] {
        SEARCH   = 2'd0,
        LOCKED   = 2'd1,
        FLYWHEEL = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_phase;
    logic [31:0] r_freq;
    logic        r_nco_en;
    logic        r_half_en;
    logic        r_lock;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [15:0] w_cnt_inc;
    logic [15:0] w_target;
    logic [32:0] w_sum;
    logic [11:0] w_mag;
    logic        w_in_band;
    logic        w_hit;
    logic        w_freeze;

    assign w_sum = {1'b0, r_phase} + {1'b0, r_freq};

    // -2048 has no positive counterpart in 12 bits, so it saturates to 2047.
    assign w_mag = bus.error[11] ? ((bus.error == 12'h800) ? 12'h7FF : -bus.error)
                                 : bus.error;

    assign w_in_band = (w_mag < bus.syncThreshold);
    assign w_target  = (bus.lockCount == '0) ? 16'd1 : bus.lockCount;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 16'd1;
    assign w_hit     = (w_cnt_inc >= w_target);

`ifdef LOOP_NCO_FLYWHEEL_EN
    assign w_freeze = (r_state == FLYWHEEL);
`else
    assign w_freeze = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            SEARCH: begin
                if (!w_in_band) begin
                    w_cnt_nxt = '0;
                end else if (w_hit) begin
                    w_state_nxt = LOCKED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            LOCKED: begin
                if (w_in_band) begin
                    w_cnt_nxt = '0;
                end else if (w_hit) begin
`ifdef LOOP_NCO_FLYWHEEL_EN
                    w_state_nxt = FLYWHEEL;
`else
                    w_state_nxt = SEARCH;
`endif
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            FLYWHEEL: begin
                if (w_in_band) begin
                    w_state_nxt = LOCKED;
                    w_cnt_nxt   = '0;
                end else if (w_hit) begin
                    w_state_nxt = SEARCH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = SEARCH;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase   <= '0;
            r_freq    <= '0;
            r_nco_en  <= 1'b0;
            r_half_en <= 1'b0;
            r_lock    <= 1'b0;
            r_cnt     <= '0;
            r_state   <= SEARCH;
        end else if (bus.clkEn) begin
            r_phase   <= w_sum[31:0];
            r_nco_en  <= w_sum[32];
            r_half_en <= ~r_phase[31] & w_sum[31];
            if (!w_freeze) begin
                r_freq <= bus.centerFreq + bus.freqIn;
            end
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_lock    <= (w_state_nxt == LOCKED) || (w_state_nxt == FLYWHEEL);
        end else begin
            r_nco_en  <= 1'b0;
            r_half_en <= 1'b0;
        end
    end

    assign bus.phase     = r_phase;
    assign bus.ncoEn     = r_nco_en;
    assign bus.ncoHalfEn = r_half_en;
    assign bus.lock      = r_lock;
    assign bus.lockState = r_state;
endmodule

// File: tb/tb_loop_nco.sv
// Bench for loop_nco: arithmetic reference model checked every cycle plus
// directed scenarios with literal expectations.
module tb_loop_nco;
    localparam logic [1:0] ST_SEARCH   = 2'd0;
    localparam logic [1:0] ST_LOCKED   = 2'd1;
    localparam logic [1:0] ST_FLYWHEEL = 2'd2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    loop_nco_if bus();

    loop_nco dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] phase;
        logic [31:0] freq;
        logic        en;
        logic        half;
        logic [1:0]  state;
        logic [15:0] cnt;
    } model_t;

    model_t m;

    function automatic model_t model_step(model_t s);
        model_t          n;
        longint unsigned sum;
        int              mag;
        int              tgt;
        int              inc;
        bit              inb;
        bit              hit;
        n = s;
        if (!bus.clkEn) begin
            n.en   = 1'b0;
            n.half = 1'b0;
            return n;
        end
        sum = s.phase;
        sum = sum + s.freq;
        n.en    = (sum >= 64'h1_0000_0000);
        n.phase = sum[31:0];
        n.half  = (s.phase < 32'h8000_0000) && (n.phase >= 32'h8000_0000);
        if (s.state != ST_FLYWHEEL) n.freq = bus.centerFreq + bus.freqIn;
        mag = $signed(bus.error);
        if (mag < 0) mag = -mag;
        if (mag > 2047) mag = 2047;
        inb = (mag < int'(bus.syncThreshold));
        tgt = (bus.lockCount == 16'd0) ? 1 : int'(bus.lockCount);
        inc = (int'(s.cnt) == 65535) ? 65535 : int'(s.cnt) + 1;
        hit = (inc >= tgt);
        case (s.state)
            ST_SEARCH: begin
                if (inb && hit) begin n.state = ST_LOCKED; n.cnt = 16'd0; end
                else if (inb)   n.cnt = 16'(inc);
                else            n.cnt = 16'd0;
            end
            ST_LOCKED: begin
                if (!inb && hit) begin
`ifdef LOOP_NCO_FLYWHEEL_EN
                    n.state = ST_FLYWHEEL;
`else
                    n.state = ST_SEARCH;
`endif
                    n.cnt = 16'd0;
                end
                else if (!inb) n.cnt = 16'(inc);
                else           n.cnt = 16'd0;
            end
            ST_FLYWHEEL: begin
                if (inb)      begin n.state = ST_LOCKED; n.cnt = 16'd0; end
                else if (hit) begin n.state = ST_SEARCH; n.cnt = 16'd0; end
                else          n.cnt = 16'(inc);
            end
            default: begin n.state = ST_SEARCH; n.cnt = 16'd0; end
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= model_step(m);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model.phase", bus.phase, m.phase);
            check("model.ncoEn", 32'(bus.ncoEn), 32'(m.en));
            check("model.ncoHalfEn", 32'(bus.ncoHalfEn), 32'(m.half));
            check("model.lockState", 32'(bus.lockState), 32'(m.state));
            check("model.lock", 32'(bus.lock), 32'(m.state != ST_SEARCH));
        end
    end

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic feed(input logic [11:0] e, input int n);
        for (int i = 0; i < n; i++) begin
            bus.error = e;
            @(negedge clk);
        end
    endtask

    logic [31:0] exp_ph   [9] = '{32'h0, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0,
                                  32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0};
    logic        exp_en   [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    logic        exp_half [9] = '{0, 0, 1, 0, 0, 0, 1, 0, 0};

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int          first_en;
        int          second_en;
        logic [31:0] p0;
        bus.clkEn         = 1'b0;
        bus.freqIn        = '0;
        bus.centerFreq    = '0;
        bus.error         = '0;
        bus.lockCount     = 16'd8;
        bus.syncThreshold = 12'd100;
        #1 reset = 1'b1;
        chk_en = 1'b1;

        // Wrap rate from reset release.
        @(negedge clk);
        check("reset.phase", bus.phase, 32'h0);
        check("reset.lockState", 32'(bus.lockState), 32'(ST_SEARCH));
        bus.centerFreq = 32'h4000_0000;
        bus.clkEn      = 1'b1;
        reset          = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("wrap.phase", bus.phase, exp_ph[i]);
            check("wrap.ncoEn", 32'(bus.ncoEn), 32'(exp_en[i]));
            check("wrap.ncoHalfEn", 32'(bus.ncoHalfEn), 32'(exp_half[i]));
        end

        // Enable gating: clkEn alternates, wrap every 8 clocks.
        do_reset();
        bus.clkEn = 1'b1;
        first_en  = -1;
        second_en = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.ncoEn) begin
                if (first_en < 0) first_en = k;
                else if (second_en < 0) second_en = k;
            end
            bus.clkEn = ~bus.clkEn;
        end
        check("gate.first_ncoEn", 32'(first_en), 32'd9);
        check("gate.ncoEn_period", 32'(second_en - first_en), 32'd8);
        bus.clkEn = 1'b1;

        // Lock acquire, plain.
        do_reset();
        feed(12'd50, 7);
        check("acq.lock_before8", 32'(bus.lock), 32'd0);
        feed(12'd50, 1);
        check("acq.lock_at8", 32'(bus.lock), 32'd1);
        check("acq.state_at8", 32'(bus.lockState), 32'(ST_LOCKED));

        // Error 99 still in band.
        do_reset();
        feed(12'd50, 3); feed(12'd99, 1); feed(12'd50, 3);
        check("acq99.lock_before8", 32'(bus.lock), 32'd0);
        feed(12'd50, 1);
        check("acq99.lock_at8", 32'(bus.lock), 32'd1);

        // Error 100 out of band restarts the count.
        do_reset();
        feed(12'd50, 3); feed(12'd100, 1); feed(12'd50, 7);
        check("acq100.lock_at11", 32'(bus.lock), 32'd0);
        feed(12'd50, 1);
        check("acq100.lock_at12", 32'(bus.lock), 32'd1);

        // Loss of lock with error -200.
        feed(12'hF38, 7);
        check("loss.state_at7", 32'(bus.lockState), 32'(ST_LOCKED));
        feed(12'hF38, 1);
`ifdef LOOP_NCO_FLYWHEEL_EN
        check("loss.state_at8", 32'(bus.lockState), 32'(ST_FLYWHEEL));
        check("loss.lock_at8", 32'(bus.lock), 32'd1);
        bus.freqIn = 32'h0100_0000;
        p0 = bus.phase;
        feed(12'hF38, 7);
        check("fly.phase_frozen_freq", bus.phase, p0 + 32'hC000_0000);
        check("fly.state_at7", 32'(bus.lockState), 32'(ST_FLYWHEEL));
        feed(12'hF38, 1);
        check("fly.state_at8", 32'(bus.lockState), 32'(ST_SEARCH));
        check("fly.lock_at8", 32'(bus.lock), 32'd0);
        bus.freqIn = '0;
        feed(12'd50, 8);
        feed(12'hF38, 8);
        check("fly2.state", 32'(bus.lockState), 32'(ST_FLYWHEEL));
        feed(12'd10, 1);
        check("fly2.relock", 32'(bus.lockState), 32'(ST_LOCKED));
        check("fly2.lock", 32'(bus.lock), 32'd1);
`else
        check("loss.state_at8", 32'(bus.lockState), 32'(ST_SEARCH));
        check("loss.lock_at8", 32'(bus.lock), 32'd0);
        bus.freqIn = 32'h0100_0000;
        p0 = bus.phase;
        feed(12'd50, 2);
        check("loss.freq_tracks", bus.phase, p0 + 32'h4000_0000 + 32'h4100_0000);
        bus.freqIn = '0;
`endif

        // lockCount lowered mid-count takes effect at once.
        do_reset();
        feed(12'd50, 5);
        bus.lockCount = 16'd3;
        feed(12'd50, 1);
        check("lc_change.lock", 32'(bus.lock), 32'd1);
        bus.lockCount = 16'd8;

        // Edge values: -2048 in band at max threshold, lockCount 0 acts as 1.
        do_reset();
        bus.syncThreshold = 12'hFFF;
        bus.lockCount     = 16'd0;
        feed(12'h800, 1);
        check("edge.min_err_lock", 32'(bus.lock), 32'd1);
        do_reset();
        bus.syncThreshold = 12'd0;
        bus.lockCount     = 16'd1;
        feed(12'd0, 20);
        check("edge.thr0_nolock", 32'(bus.lock), 32'd0);
        bus.syncThreshold = 12'd100;
        bus.lockCount     = 16'd8;

        // Asynchronous reset while locked.
        do_reset();
        feed(12'd50, 8);
        check("rst.locked", 32'(bus.lock), 32'd1);
        check("rst.phase_nonzero", 32'(bus.phase != 32'h0), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst.async_phase", bus.phase, 32'h0);
        check("rst.async_ncoEn", 32'(bus.ncoEn), 32'd0);
        check("rst.async_half", 32'(bus.ncoHalfEn), 32'd0);
        check("rst.async_lock", 32'(bus.lock), 32'd0);
        check("rst.async_state", 32'(bus.lockState), 32'(ST_SEARCH));
        @(negedge clk);
        reset = 1'b0;
        feed(12'd50, 8);
        check("rst.reacquire", 32'(bus.lock), 32'd1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
